imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the word-addressed instruction memory. Receives a program as a
//  byte stream (valid/ready), assembles little-endian 32-bit words and writes
//  them sequentially from word 0. Holds the core in reset until the load is done.
//  Sits between the byte source (UART/debug bridge) and the memory write port.
// PARAMETERS
//  DATA_WIDTH    32   word width; the byte-assembly logic is fixed at 4 bytes/word
//  MEM_CAPACITY  10   number of memory words; the maximum loadable word count
// PORTS
//  clk         in   1           rising-edge clock
//  rstn        in   1           reset, asynchronous, active-low
//  start       in   1           1-cycle pulse, begins a load
//  s_valid     in   1           byte-stream valid
//  s_data      in   8           byte-stream data
//  s_ready     out  1           loader accepts a byte this cycle
//  mem_we      out  1           memory write strobe, 1 cycle per word
//  mem_addr    out  DATA_WIDTH  word index; not a byte address
//  mem_wdata   out  DATA_WIDTH  assembled word
//  busy        out  1           load in progress
//  done        out  1           load completed successfully; sticky
//  error       out  1           word count > MEM_CAPACITY; sticky
//  cpu_rstn_o  out  1           core reset, active-low; high only in DONE
// BEHAVIOUR
//  - Reset (rstn=0, async): state=IDLE. All outputs are 0, including cpu_rstn_o,
//    s_ready, mem_we, mem_addr and mem_wdata. The byte counter, word index and N
//    register are also cleared.
//  - Handshake: a byte transfers when s_valid && s_ready. s_ready is a Moore
//    output: 1 in LEN0/LEN1/DATA, 0 elsewhere. s_data is sampled only on transfer.
//  - Frame format: N[7:0], N[15:8] (word count, 16 bit), then N*4 data bytes,
//    LSB first within each word.
//  - States:
//    IDLE : start -> LEN0.
//    LEN0 : on transfer, capture N low byte -> LEN1.
//    LEN1 : on transfer, capture N high byte, then evaluate N:
//             N==0            -> DONE
//             N>MEM_CAPACITY  -> ERR
//             otherwise       -> DATA
//           N is evaluated on the full 16-bit value.
//    DATA : on each transfer, shift the byte into lane byte_cnt, byte_cnt++.
//           The 4th transfer -> WRITE.
//    WRITE: exactly 1 cycle. mem_we=1, mem_addr=word_idx,
//           mem_wdata={b3,b2,b1,b0}, s_ready=0. Then word_idx++, byte_cnt=0.
//           If word_idx+1==N -> DONE, else -> DATA.
//    DONE : done=1, cpu_rstn_o=1. start -> LEN0 (clears done, word_idx, N).
//    ERR  : error=1, cpu_rstn_o=0, s_ready=0. start -> LEN0 (clears error).
//  - Latency: mem_we is asserted in the cycle after the 4th byte of a word is
//    accepted. Peak throughput is 1 word per 5 cycles.
//  - Outputs: busy=1 in LEN0/LEN1/DATA/WRITE. cpu_rstn_o=0 in every state except
//    DONE. mem_addr/mem_wdata hold their last value when mem_we=0.
//  - start while busy or in IDLE-entry transitions: start is ignored in
//    LEN0/LEN1/DATA/WRITE; there is no abort path other than rstn.
//  - s_valid without start: bytes arriving in IDLE/DONE/ERR are not accepted
//    (s_ready=0); the stream stalls.
//  - word_idx/mem_addr: the index never exceeds MEM_CAPACITY-1, guaranteed by
//    the N check. No wrap-around is possible.
//  - Reset mid-load: immediate return to IDLE. Words already written stay in
//    memory; cpu_rstn_o stays 0.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE..ERR, 3 bits),
//    BYTES_PER_WORD=4, LEN_BYTES=2.
//  - One sub-module, imem_word_packer: byte_cnt plus a 4-lane shift/assemble
//    register, with a word_ready flag and a clear input. FSM, N register and
//    word_idx stay in imem_loader.
// TESTING
//  1. Reset mid-DATA: assert rstn=0 after 2 data bytes -> all outputs 0 async,
//     state IDLE, and no mem_we pulse follows.
//  2. start, bytes 02 00 | 03 A3 C4 FF | 23 A4 64 00 ->
//     mem_we pulses with (addr 0, FFC4A303) and (addr 1, 0064A423); then
//     done=1, cpu_rstn_o=1, busy=0.
//  3. Same frame with s_valid toggling every other cycle -> identical writes,
//     no byte lost or duplicated, and s_ready=0 during each WRITE cycle.
//  4. start, bytes 0B 00 (N=11 > 10) -> error=1, cpu_rstn_o=0, zero mem_we
//     pulses. A second start plus a valid N=1 frame -> error=0, done=1.
//  5. start, bytes 00 00 -> DONE the cycle after the 2nd byte; no mem_we pulse.
//  6. start pulsed during DATA -> ignored, and the load completes normally.
//     N=10 frame -> last write at addr 9, then DONE.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader: FSM encoding and frame geometry.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Collects bytes LSB-first into a 4-lane word; word_o already includes the byte pushed this cycle,
// so the word is usable on the same edge that accepts its last byte. No backpressure of its own.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  logic [7:0]                  data_i,
  output logic [8*BYTES_PER_WORD-1:0] word_o,
  output logic                        word_ready_o
);

  logic [CNT_W-1:0] byte_cnt_q;
  logic [7:0]       lane_q [BYTES_PER_WORD];

  assign word_ready_o = push_i && (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_comb begin
    word_o = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      word_o[8*i +: 8] = (push_i && byte_cnt_q == CNT_W'(i)) ? data_i : lane_q[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt_q <= '0;
      for (int i = 0; i < BYTES_PER_WORD; i++) lane_q[i] <= '0;
    end else if (clear_i) begin
      byte_cnt_q <= '0;
    end else if (push_i) begin
      lane_q[byte_cnt_q] <= data_i;
      byte_cnt_q         <= byte_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory word by word, holding the core in reset.
// mem_we follows the 4th byte of a word by one cycle; s_ready drops outside LEN0/LEN1/DATA.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_CAPACITY = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_rstn_o
);

  localparam logic [LEN_W-1:0] CAP = LEN_W'(MEM_CAPACITY);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        n_q, word_idx_q, n_full;
  logic                    s_ready_q, mem_we_q, busy_q, done_q, error_q, cpu_rstn_q;
  logic [DATA_WIDTH-1:0]   mem_addr_q, mem_wdata_q;
  logic                    xfer, start_acc, pk_push, pk_clear, pk_ready;
  logic [8*BYTES_PER_WORD-1:0] pk_word;

  assign xfer      = s_valid && s_ready_q;
  assign start_acc = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign n_full    = {s_data, n_q[7:0]};
  assign pk_push   = xfer && (state_q == ST_DATA);
  assign pk_clear  = start_acc || (state_q == ST_WRITE);

  imem_word_packer u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .clear_i      (pk_clear),
    .push_i       (pk_push),
    .data_i       (s_data),
    .word_o       (pk_word),
    .word_ready_o (pk_ready)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LEN0;
      ST_LEN0:  if (xfer) state_d = ST_LEN1;
      ST_LEN1: begin
        if (xfer) begin
          if (n_full == '0)     state_d = ST_DONE;
          else if (n_full > CAP) state_d = ST_ERR;
          else                   state_d = ST_DATA;
        end
      end
      ST_DATA:  if (pk_ready) state_d = ST_WRITE;
      ST_WRITE: state_d = (word_idx_q + 1'b1 == n_q) ? ST_DONE : ST_DATA;
      ST_DONE:  if (start) state_d = ST_LEN0;
      ST_ERR:   if (start) state_d = ST_LEN0;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      word_idx_q  <= '0;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rstn_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= state_d inside {ST_LEN0, ST_LEN1, ST_DATA};
      busy_q     <= state_d inside {ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE};
      done_q     <= (state_d == ST_DONE);
      error_q    <= (state_d == ST_ERR);
      cpu_rstn_q <= (state_d == ST_DONE);
      mem_we_q   <= (state_d == ST_WRITE);
      if (start_acc) begin
        n_q        <= '0;
        word_idx_q <= '0;
      end
      if (xfer && state_q == ST_LEN0) n_q[7:0]       <= s_data;
      if (xfer && state_q == ST_LEN1) n_q[LEN_W-1:8] <= s_data;
      if (pk_ready) begin
        mem_addr_q  <= DATA_WIDTH'(word_idx_q);
        mem_wdata_q <= DATA_WIDTH'(pk_word);
      end
      if (state_q == ST_WRITE) word_idx_q <= word_idx_q + 1'b1;
    end
  end

  assign s_ready    = s_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_rstn_o = cpu_rstn_q;

endmodule
